// File: rtl/spi_link_pkg.sv
// spi_link_pkg: shared FSM state encoding and default packet width for the serial link.
package spi_link_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;
   localparam int unsigned PACKET_LENGTH = 32;
endpackage

// File: rtl/sclk_divider.sv
// sclk_divider: free-running serial clock with a one-cycle strobe ahead of each falling edge.
module sclk_divider #(
   parameter int unsigned DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic sclk_o,
   output logic fall_o
);
   localparam int unsigned CW = DIV > 1 ? $clog2(DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d, wrap;

   always_comb begin
      wrap   = cnt_q == CW'(DIV - 1);
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      sclk_d = wrap ? ~sclk_q : sclk_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   // Strobe fires in the cycle whose closing edge drives sclk low.
   assign fall_o = wrap & sclk_q;
endmodule

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: MSB-first serializer with a one-word holding register and fixed inter-packet gap.
module spi_tx_serializer
   import spi_link_pkg::*;
#(
   parameter int unsigned packet_length = PACKET_LENGTH,
   parameter int unsigned DIV           = 2,
   parameter int unsigned GAP           = 1
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [packet_length-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic                     sclk,
   output logic                     sdata,
   output logic                     svalid,
   output logic                     busy,
   output logic                     tx_done
);
   localparam int unsigned BW = $clog2(packet_length);
   localparam int unsigned GW = GAP > 1 ? $clog2(GAP) : 1;

   state_e                   state_q, state_d;
   logic [packet_length-1:0] hold_q, hold_d, shift_q, shift_d;
   logic                     hold_full_q, hold_full_d, svalid_q, svalid_d, done_q, done_d;
   logic [BW-1:0]            bit_q, bit_d;
   logic [GW-1:0]            gap_q, gap_d;
   logic                     fall, accept, load;

   sclk_divider #(.DIV(DIV)) u_div (
      .clk_i (aclk),
      .rst_i (areset),
      .sclk_o(sclk),
      .fall_o(fall)
   );

   always_comb begin
      accept      = s_valid && s_ready;
      load        = fall && hold_full_q && (state_q == ST_IDLE || (state_q == ST_GAP && gap_q == '0));
      hold_full_d = accept | (hold_full_q & ~load);
      hold_d      = accept ? s_data : hold_q;
      state_d     = state_q;
      shift_d     = shift_q;
      svalid_d    = svalid_q;
      bit_d       = bit_q;
      gap_d       = gap_q;
      done_d      = 1'b0;
      if (load) begin
         state_d  = ST_SHIFT;
         shift_d  = hold_q;
         svalid_d = 1'b1;
         bit_d    = BW'(packet_length - 1);
      end else if (fall && state_q == ST_SHIFT) begin
         if (bit_q != '0) begin
            shift_d = shift_q << 1;
            bit_d   = bit_q - 1'b1;
         end else begin
            // Clearing the shifter also returns sdata to 0 for the gap.
            shift_d  = '0;
            svalid_d = 1'b0;
            done_d   = 1'b1;
            gap_d    = GW'(GAP - 1);
            state_d  = ST_GAP;
         end
      end else if (fall && state_q == ST_GAP) begin
         gap_d   = gap_q != '0 ? gap_q - 1'b1 : gap_q;
         state_d = gap_q != '0 ? ST_GAP : ST_IDLE;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         svalid_q    <= 1'b0;
         bit_q       <= '0;
         gap_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         svalid_q    <= svalid_d;
         bit_q       <= bit_d;
         gap_q       <= gap_d;
         done_q      <= done_d;
      end
   end

   assign s_ready = ~hold_full_q & ~areset;
   assign sdata   = shift_q[packet_length-1];
   assign svalid  = svalid_q;
   assign busy    = state_q != ST_IDLE || hold_full_q;
   assign tx_done = done_q;
endmodule
